// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// func3 encodings, FSM state type and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        logic s;
        s = 1'b0;
        case (f3)
            F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        logic s;
        s = 1'b0;
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, with busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_neg_s, b_neg_s, div0_s, ovf_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [XLEN:0]     mul_sum_s, rem_sh_s, rem_diff_s;
    logic [2*XLEN-1:0] mul_step_s, div_step_s, prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s;

    // Operand magnitudes, signs and special-case detection at issue
    always_comb begin
        a_neg_s = rs1_signed(func3) & rs1[XLEN-1];
        b_neg_s = rs2_signed(func3) & rs2[XLEN-1];
        a_mag_s = a_neg_s ? -rs1 : rs1;
        b_mag_s = b_neg_s ? -rs2 : rs2;
        div0_s  = is_div(func3) && (rs2 == '0);
        ovf_s   = is_div(func3) && rs2_signed(func3) && (rs1 == MIN_NEG) && (rs2 == '1);
    end

    // One iteration of each algorithm plus the final sign fix
    always_comb begin
        // Multiply: multiplier sits in the low half and shifts out LSB-first.
        mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});
        mul_step_s = {mul_sum_s, acc_q[XLEN-1:1]};
        // Divide: {remainder, quotient} shifts left; the extra bit absorbs 2*rem overflow.
        rem_sh_s   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff_s = rem_sh_s - {1'b0, op_q};
        if (rem_diff_s[XLEN]) begin
            div_step_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_step_s = {rem_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        prod_fix_s = neg_q ? -acc_q : acc_q;
        quo_fix_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    // FSM next state, datapath loads and output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        f3_d  = func3;
                        cnt_d = '0;
                        if (div0_s) begin
                            acc_d   = {rs1, {XLEN{1'b1}}};
                            neg_d   = 1'b0;
                            state_d = ST_DONE;
                        end else if (ovf_s) begin
                            acc_d   = {{XLEN{1'b0}}, rs1};
                            neg_d   = 1'b0;
                            state_d = ST_DONE;
                        end else if (is_div(func3)) begin
                            op_d    = b_mag_s;
                            acc_d   = {{XLEN{1'b0}}, a_mag_s};
                            // Remainder takes the dividend's sign, quotient the XOR.
                            neg_d   = func3[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                            state_d = ST_CALC;
                        end else begin
                            op_d    = a_mag_s;
                            acc_d   = {{XLEN{1'b0}}, b_mag_s};
                            neg_d   = a_neg_s ^ b_neg_s;
                            state_d = ST_CALC;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_d = is_div(f3_q) ? div_step_s : mul_step_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    case (f3_q)
                        F3_MUL:                        result_d = prod_fix_s[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU:  result_d = prod_fix_s[2*XLEN-1:XLEN];
                        F3_DIV, F3_DIVU:               result_d = quo_fix_s;
                        default:                       result_d = rem_fix_s;
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // busy stays up through the done cycle so the pipeline sees one clean release.
        busy_d = (state_d != ST_IDLE) | done_d;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= 3'b000;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model and a
// per-cycle timing model checked against busy/done/result after every edge.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec;
    int n_err;
    int cyc;

    // Timing model: edge of acceptance, done edge, last busy edge
    bit          m_active;
    int          m_acc;
    int          m_done_edge;
    int          m_busy_last;
    logic [31:0] m_res_prev;
    logic [31:0] m_res_new;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0]        pu;
        logic signed [31:0] qa, qb;
        logic               ovf;
        logic [31:0]        r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'h0, b};
        pu  = {32'h0, a} * {32'h0, b};
        qa  = a;
        qb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: r = pu[63:32];
            3'd4: r = (b == 32'h0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(qa / qb));
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 32'h0) ? a : (ovf ? 32'h0 : 32'(qa % qb));
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Per-edge compare of all outputs against the timing model
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            chk("busy", {31'h0, busy},
                {31'h0, m_active && (cyc >= m_acc) && (cyc <= m_busy_last)});
            chk("done", {31'h0, done}, {31'h0, m_active && (cyc == m_done_edge)});
            chk("result", result,
                (m_active && (cyc >= m_done_edge)) ? m_res_new : m_res_prev);
        end
    end

    // Issue one op; optionally flush, toggle start, or reset at a CALC offset
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int flush_at, input int toggle_at,
                          input int rst_at);
        bit special;
        int rel;
        @(negedge clk);
        m_res_prev  = (m_active && (cyc >= m_done_edge)) ? m_res_new : m_res_prev;
        special     = f[2] && ((b == 32'h0) ||
                      (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        m_res_new   = ref_op(f, a, b);
        chk("model", m_res_new, lit);
        func3       = f;
        rs1         = a;
        rs2         = b;
        start       = 1'b1;
        m_acc       = cyc + 1;
        m_done_edge = m_acc + (special ? 1 : 33);
        m_busy_last = m_done_edge;
        m_active    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rel = cyc - m_acc;
            start = 1'b0;
            flush = 1'b0;
            if (toggle_at > 0 && (rel == toggle_at || rel == toggle_at + 1)) begin
                start = 1'b1;
                func3 = 3'd0;
                rs1   = 32'h1234_5678;
                rs2   = 32'h0000_0003;
            end
            if (flush_at > 0 && rel == flush_at - 1) begin
                flush       = 1'b1;
                m_busy_last = cyc;
                m_done_edge = 32'h7FFF_FFFF;
            end
            if (rst_at > 0 && rel == rst_at) begin
                rst_n      = 1'b0;
                m_active   = 1'b0;
                m_res_prev = 32'h0;
                #1;
                chk("async_busy", {31'h0, busy}, 32'h0);
                chk("async_done", {31'h0, done}, 32'h0);
                chk("async_result", result, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (!m_active || cyc > m_busy_last) break;
        end
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        m_active    = 1'b0;
        m_acc       = 0;
        m_done_edge = 0;
        m_busy_last = 0;
        m_res_prev  = 32'h0;
        m_res_new   = 32'h0;
        rst_n       = 1'b0;
        start       = 1'b0;
        flush       = 1'b0;
        func3       = 3'd0;
        rs1         = 32'h0;
        rs2         = 32'h0;
        #1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, 0);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0, 0, 0);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(3'd1, 32'hFFFF_FFFB,  32'd3,         32'hFFFF_FFFF, 0, 0, 0);
        run_op(3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 0, 0, 0);
        run_op(3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 0, 0, 0);
        run_op(3'd5, 32'd100,        32'd7,         32'd14,        0, 0, 0);
        run_op(3'd7, 32'd100,        32'd7,         32'd2,         0, 0, 0);
        run_op(3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, 0);
        run_op(3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         0, 0, 0);
        run_op(3'd4, 32'd5,          32'h0,         32'hFFFF_FFFF, 0, 0, 0);
        run_op(3'd7, 32'd5,          32'h0,         32'd5,         0, 0, 0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         0, 0, 0);
        // Flushed op: result keeps the previous value (0 from REM overflow).
        run_op(3'd5, 32'd1000,       32'd9,         32'd111,       10, 0, 0);
        run_op(3'd5, 32'd1000,       32'd9,         32'd111,       0, 5, 0);
        run_op(3'd0, 32'd12345,      32'd678,       32'd8369910,   0, 0, 12);
        run_op(3'd0, 32'd12345,      32'd678,       32'd8369910,   0, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
